// File: rtl/irq_exc_if.sv
// Bundle between the decode stage and the interrupt/exception controller.
// The master drives the requests and ID-stage status; the slave (controller)
// answers with the redirect, kernel-mode and saved-state signals.
interface irq_exc_if #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 32
);
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic             id_valid;
  logic             id_stall;
  logic [PC_W-1:0]  id_pc;
  logic             undef_op;
  logic             eret;
  logic             ker;
  logic             take_irq;
  logic             take_exc;
  logic             flush_id;
  logic [PC_W-1:0]  epc;
  logic [4:0]       cause;
  logic [N_IRQ-1:0] irq_ack;

  modport master (
    output irq_in, irq_mask, id_valid, id_stall, id_pc, undef_op, eret,
    input  ker, take_irq, take_exc, flush_id, epc, cause, irq_ack
  );

  modport slave (
    input  irq_in, irq_mask, id_valid, id_stall, id_pc, undef_op, eret,
    output ker, take_irq, take_exc, flush_id, epc, cause, irq_ack
  );
endinterface

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller for the pipelined MIPS core.
// Synchronises and latches external IRQ edges, arbitrates them against
// undefined-opcode exceptions, redirects the front end, saves EPC/cause and
// tracks kernel mode until the handler returns with jr $26.
module irq_exc_ctrl #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 32,
  parameter int SYNC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  irq_exc_if.slave    bus
);

  typedef enum logic [1:0] {USER, ENTER, KERNEL} state_t;

  state_t                      state_q, state_d;
  logic                        ker_q, ker_d;
  logic [PC_W-1:0]             epc_q, epc_d;
  logic [4:0]                  cause_q, cause_d;
  logic [SYNC-1:0][N_IRQ-1:0]  sync_q, sync_d;
  logic [N_IRQ-1:0]            prev_q, prev_d;
  logic [N_IRQ-1:0]            pending_q, pending_d;

  logic [N_IRQ-1:0]            synced;
  logic [N_IRQ-1:0]            rise;
  logic [N_IRQ-1:0]            eligible;
  logic                        irq_found;
  logic [3:0]                  irq_idx;
  logic                        accept;
  logic                        take_irq;
  logic                        take_exc;
  logic [N_IRQ-1:0]            irq_ack;

  // Shift the raw request lines through the synchroniser chain and keep the
  // previous synchronised value for rising-edge detection.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.irq_in;
    for (int i = 1; i < SYNC; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    synced = sync_q[SYNC-1];
    prev_d = synced;
    rise   = synced & ~prev_q;
  end

  // Lowest-index enabled pending line wins among the IRQs.
  always_comb begin
    eligible  = pending_q & bus.irq_mask;
    irq_found = 1'b0;
    irq_idx   = 4'd0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (eligible[i] && !irq_found) begin
        irq_found = 1'b1;
        irq_idx   = 4'(i);
      end
    end
  end

  // Mode FSM: decide redirects in USER, hold one ENTER cycle, wait for eret in KERNEL.
  always_comb begin
    state_d  = state_q;
    ker_d    = ker_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    take_irq = 1'b0;
    take_exc = 1'b0;
    irq_ack  = '0;
    // A redirect needs a real, unstalled ID instruction; reset low blocks it
    // so nothing fires combinationally while the core is held in reset.
    accept   = reset & bus.id_valid & ~bus.id_stall;
    case (state_q)
      USER: begin
        if (accept && bus.undef_op) begin
          take_exc = 1'b1;
          epc_d    = bus.id_pc + PC_W'(4);
          cause_d  = 5'h10;
          ker_d    = 1'b1;
          state_d  = ENTER;
        end else if (accept && irq_found) begin
          take_irq = 1'b1;
          epc_d    = bus.id_pc;
          cause_d  = {1'b0, irq_idx};
          irq_ack  = N_IRQ'(1) << irq_idx;
          ker_d    = 1'b1;
          state_d  = ENTER;
        end
      end
      ENTER: begin
        state_d = KERNEL;
      end
      KERNEL: begin
        // Undefined opcodes inside the handler are ignored; only eret leaves.
        if (accept && bus.eret) begin
          ker_d   = 1'b0;
          state_d = USER;
        end
      end
      default: begin
        state_d = USER;
        ker_d   = 1'b0;
      end
    endcase
    // A new edge in the same cycle as the acknowledge keeps the line pending.
    pending_d = (pending_q & ~irq_ack) | rise;
  end

  // State, mode, saved context and IRQ bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= USER;
      ker_q     <= 1'b0;
      epc_q     <= '0;
      cause_q   <= '0;
      sync_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ker_q     <= ker_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  assign bus.ker      = ker_q;
  assign bus.take_irq = take_irq;
  assign bus.take_exc = take_exc;
  assign bus.flush_id = take_irq | take_exc;
  assign bus.epc      = epc_q;
  assign bus.cause    = cause_q;
  assign bus.irq_ack  = irq_ack;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Bench for irq_exc_ctrl: expected redirect events go into a scoreboard queue
// when stimulus is applied; a negedge monitor pops and compares them.
module tb_irq_exc_ctrl;
  localparam int N_IRQ = 4;
  localparam int PC_W  = 32;
  localparam int SYNC  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_exc_if #(.N_IRQ(N_IRQ), .PC_W(PC_W)) bus ();
  irq_exc_ctrl #(.N_IRQ(N_IRQ), .PC_W(PC_W), .SYNC(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        exc;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic [3:0]  ack;
  } ev_t;

  typedef struct {
    logic [3:0]  lines;
    logic        undef;
    logic [31:0] pc;
    logic [3:0]  mask;
    int          n;
    ev_t         e0;
    ev_t         e1;
  } vec_t;

  ev_t  sb[$];
  ev_t  mon_e;
  ev_t  post_ev;
  logic post_chk = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic exc, input logic [4:0] cause,
                             input logic [31:0] epc, input logic [3:0] ack);
    ev_t e;
    e.exc = exc; e.cause = cause; e.epc = epc; e.ack = ack;
    return e;
  endfunction

  // Compare every redirect against the scoreboard; epc/cause one cycle later.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (post_chk) begin
        chk("epc", bus.epc, post_ev.epc);
        chk("cause", 32'(bus.cause), 32'(post_ev.cause));
        post_chk = 1'b0;
      end
      if (bus.take_irq || bus.take_exc) begin
        chk("take_exclusive", 32'(bus.take_irq & bus.take_exc), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_take", 32'({bus.take_irq, bus.take_exc}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("take_exc", 32'(bus.take_exc), 32'(mon_e.exc));
          chk("take_irq", 32'(bus.take_irq), 32'(!mon_e.exc));
          chk("flush_id", 32'(bus.flush_id), 32'd1);
          chk("irq_ack", 32'(bus.irq_ack), 32'(mon_e.ack));
          post_ev  = mon_e;
          post_chk = 1'b1;
        end
      end
    end else begin
      post_chk = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_take(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      #1;
      if (bus.take_irq || bus.take_exc) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: take not seen within 12 cycles, got 0 expected 1", name);
    end
  endtask

  // Commit the take, check kernel mode, then return with eret.
  task automatic handle_kernel(input string name);
    step();
    bus.undef_op = 1'b0;
    bus.irq_in   = '0;
    chk({name, "_ker_set"}, 32'(bus.ker), 32'd1);
    step();
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    chk({name, "_ker_clr"}, 32'(bus.ker), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lines: 4'b1010, undef: 1'b0, pc: 32'h0000_2000, mask: 4'hF, n: 2,
                e0: mk(1'b0, 5'h01, 32'h0000_2000, 4'b0010),
                e1: mk(1'b0, 5'h03, 32'h0000_2000, 4'b1000)};
    vecs[1] = '{lines: 4'b0001, undef: 1'b1, pc: 32'h0000_0100, mask: 4'hF, n: 2,
                e0: mk(1'b1, 5'h10, 32'h0000_0104, 4'b0000),
                e1: mk(1'b0, 5'h00, 32'h0000_0100, 4'b0001)};
    vecs[2] = '{lines: 4'b0000, undef: 1'b1, pc: 32'hFFFF_FFFC, mask: 4'hF, n: 1,
                e0: mk(1'b1, 5'h10, 32'h0000_0000, 4'b0000),
                e1: mk(1'b0, 5'h00, 32'h0, 4'b0)};
    vecs[3] = '{lines: 4'b1000, undef: 1'b0, pc: 32'h0000_1234, mask: 4'b1000, n: 1,
                e0: mk(1'b0, 5'h03, 32'h0000_1234, 4'b1000),
                e1: mk(1'b0, 5'h00, 32'h0, 4'b0)};

    bus.irq_in = '0; bus.irq_mask = '0; bus.id_valid = 1'b0; bus.id_stall = 1'b0;
    bus.id_pc = '0; bus.undef_op = 1'b0; bus.eret = 1'b0;
    reset = 1'b0;

    // Reset held while the request lines toggle.
    bus.irq_mask = 4'hF;
    bus.id_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.irq_in = ~bus.irq_in;
      #1;
      chk("rst_ker", 32'(bus.ker), 32'd0);
      chk("rst_take", 32'({bus.take_irq, bus.take_exc}), 32'd0);
      chk("rst_epc", bus.epc, 32'd0);
    end
    bus.irq_in = '0;
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_take", 32'({bus.take_irq, bus.take_exc}), 32'd0);
    end
    chk("post_rst_cause", 32'(bus.cause), 32'd0);

    // IRQ latency from a rising request to take_irq.
    bus.id_pc  = 32'h0040_0010;
    sb.push_back(mk(1'b0, 5'h02, 32'h0040_0010, 4'b0100));
    bus.irq_in = 4'b0100;
    step();
    step();
    #1;
    chk("lat_early", 32'(bus.take_irq), 32'd0);
    step();
    chk("lat_take", 32'(bus.take_irq), 32'd1);
    handle_kernel("lat");

    // Table of events: lines latched under bubbles, then ID goes valid.
    for (int v = 0; v < 4; v++) begin
      bus.id_valid = 1'b0;
      bus.irq_mask = vecs[v].mask;
      bus.id_pc    = vecs[v].pc;
      bus.irq_in   = vecs[v].lines;
      repeat (SYNC + 3) step();
      sb.push_back(vecs[v].e0);
      if (vecs[v].n == 2) sb.push_back(vecs[v].e1);
      bus.id_valid = 1'b1;
      bus.undef_op = vecs[v].undef;
      for (int k = 0; k < vecs[v].n; k++) begin
        wait_take($sformatf("vec%0d_take%0d", v, k));
        handle_kernel($sformatf("vec%0d_%0d", v, k));
      end
      bus.id_valid = 1'b0;
      step();
      step();
      chk($sformatf("vec%0d_drained", v), 32'(sb.size()), 32'd0);
    end

    // Masked line, then stalled pipeline, then release.
    bus.id_pc    = 32'h0000_3000;
    bus.irq_mask = 4'b0000;
    bus.id_valid = 1'b1;
    bus.irq_in   = 4'b0001;
    repeat (5) step();
    bus.irq_mask = 4'b0001;
    bus.id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_take", 32'({bus.take_irq, bus.take_exc}), 32'd0);
    end
    sb.push_back(mk(1'b0, 5'h00, 32'h0000_3000, 4'b0001));
    bus.id_stall = 1'b0;
    #1;
    chk("stall_release_take", 32'(bus.take_irq), 32'd1);
    handle_kernel("stall");

    // Kernel mode ignores IRQs and undefined opcodes; reset exits the handler.
    bus.irq_mask = 4'hF;
    bus.id_pc    = 32'h0000_4000;
    sb.push_back(mk(1'b0, 5'h01, 32'h0000_4000, 4'b0010));
    bus.irq_in = 4'b0010;
    wait_take("kern_entry");
    step();
    chk("kern_ker", 32'(bus.ker), 32'd1);
    bus.irq_in = 4'b0100;
    bus.undef_op = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("kern_no_take", 32'({bus.take_irq, bus.take_exc}), 32'd0);
    end
    chk("kern_cause", 32'(bus.cause), 32'h01);
    bus.undef_op = 1'b0;
    sb.push_back(mk(1'b0, 5'h02, 32'h0000_4000, 4'b0100));
    bus.eret = 1'b1;
    step();
    bus.eret = 1'b0;
    chk("kern_eret_ker", 32'(bus.ker), 32'd0);
    wait_take("kern_irq2");
    step();
    bus.irq_in = 4'b1000;
    chk("kern2_ker", 32'(bus.ker), 32'd1);
    repeat (4) step();
    chk("kern2_no_take", 32'({bus.take_irq, bus.take_exc}), 32'd0);
    bus.irq_in = '0;
    reset = 1'b0;
    #1;
    chk("mid_rst_ker", 32'(bus.ker), 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_pending_clear", 32'({bus.take_irq, bus.take_exc}), 32'd0);
    end
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
